// File: rtl/md_sequencer_if.sv
// EX-side request/response bundle for the RV32M multiply/divide sequencer.
interface md_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, src_a, src_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, src_a, src_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/md_sequencer.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply, restoring divide.
// Optional macro MD_ZERO_BYPASS_EN short-circuits zero-operand cases from PREP.
module md_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    md_sequencer_if.slave    bus
);
    localparam int unsigned      PW      = 2 * XLEN;
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opa_q, opb_q;
    logic [XLEN-1:0]   mcand_q;
    logic [PW-1:0]     acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, rem_neg_q;
    logic [XLEN-1:0]   result_q;

    logic              is_div_c, sign_a_en_c, sign_b_en_c, sa_c, sb_c;
    logic [XLEN-1:0]   abs_a_c, abs_b_c;
    logic              special_c;
    logic [XLEN-1:0]   special_res_c;
    logic [XLEN:0]     mul_sum_c, rem_sh_c, diff_c;
    logic [PW-1:0]     mul_step_c, div_step_c, prod_fix_c;
    logic [XLEN-1:0]   quo_fix_c, rem_fix_c, fix_res_c;

    // Operand signedness: MULH/DIV/REM sign both, MULHSU signs A only.
    always_comb begin
        is_div_c    = op_q[2];
        sign_a_en_c = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        sign_b_en_c = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
        sa_c        = sign_a_en_c & opa_q[XLEN-1];
        sb_c        = sign_b_en_c & opb_q[XLEN-1];
        abs_a_c     = sa_c ? -opa_q : opa_q;
        abs_b_c     = sb_c ? -opb_q : opb_q;
    end

    // Early-exit cases resolved in PREP without iterating.
    always_comb begin
        special_c     = 1'b0;
        special_res_c = '0;
        if (is_div_c && (opb_q == '0)) begin
            special_c     = 1'b1;
            special_res_c = op_q[1] ? opa_q : '1;
        end else if (is_div_c && !op_q[0] && (opa_q == MIN_NEG) && (&opb_q)) begin
            special_c     = 1'b1;
            special_res_c = op_q[1] ? '0 : MIN_NEG;
        end
`ifdef MD_ZERO_BYPASS_EN
        else if (!is_div_c && ((opa_q == '0) || (opb_q == '0))) begin
            special_c = 1'b1;
        end else if (is_div_c && (opa_q == '0)) begin
            special_c = 1'b1;
        end
`endif
    end

    // One iteration of each algorithm; acc holds {product} or {remainder, quotient}.
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
        rem_sh_c   = acc_q[PW-1:XLEN-1];
        diff_c     = rem_sh_c - {1'b0, mcand_q};
        div_step_c = diff_c[XLEN] ? {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {diff_c[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    end

    // Sign fix-up and output selection.
    always_comb begin
        prod_fix_c = neg_q ? -acc_q : acc_q;
        quo_fix_c  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix_c  = rem_neg_q ? -acc_q[PW-1:XLEN] : acc_q[PW-1:XLEN];
        if (is_div_c)
            fix_res_c = op_q[1] ? rem_fix_c : quo_fix_c;
        else if (op_q[1:0] == 2'b00)
            fix_res_c = prod_fix_c[XLEN-1:0];
        else
            fix_res_c = prod_fix_c[PW-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bus.stall = 1'b0;
        bus.busy  = (state_q != S_IDLE);
        bus.done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d   = S_PREP;
                    bus.stall = 1'b1;
                end
            end
            S_PREP: begin
                bus.stall = 1'b1;
                state_d   = special_c ? S_DONE : S_CALC;
            end
            S_CALC: begin
                bus.stall = 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                bus.stall = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Datapath; RESULT loads on the edge into DONE so it is valid with the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else if (bus.flush && (state_q != S_IDLE)) begin
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        op_q  <= bus.funct3;
                        opa_q <= bus.src_a;
                        opb_q <= bus.src_b;
                    end
                end
                S_PREP: begin
                    cnt_q     <= '0;
                    neg_q     <= sa_c ^ sb_c;
                    rem_neg_q <= sa_c;
                    if (is_div_c) begin
                        acc_q   <= {{XLEN{1'b0}}, abs_a_c};
                        mcand_q <= abs_b_c;
                    end else begin
                        acc_q   <= {{XLEN{1'b0}}, abs_b_c};
                        mcand_q <= abs_a_c;
                    end
                    if (special_c) result_q <= special_res_c;
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    acc_q <= is_div_c ? div_step_c : mul_step_c;
                end
                S_FIX:   result_q <= fix_res_c;
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
endmodule
